// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the HILO divide controller: FSM state encodings
// and the ready/start strobe constants.
package hilo_div_ctrl_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/hilo_div_ctrl_div_step.sv
// One radix-2 restoring divide iteration: 33-bit trial subtract of the divisor
// from {partial remainder, next dividend bit}, keeping the difference if it is non-negative.
module hilo_div_ctrl_div_step (
    input  logic [31:0] part_rem,
    input  logic        dvd_bit,
    input  logic [31:0] divisor,
    output logic [31:0] next_rem,
    output logic        q_bit
);

    logic [32:0] trial;
    logic [32:0] diff;

    always_comb begin
        trial = {part_rem, dvd_bit};
        diff  = trial - {1'b0, divisor};
        // Remainder stays below the divisor, so bit 32 of the wrapped difference is its sign
        q_bit    = ~diff[32];
        next_rem = q_bit ? diff[31:0] : trial[31:0];
    end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Iterative 32-bit DIV/DIVU controller: 32-cycle restoring divide, pipeline
// stall while busy, and a single-cycle {remainder, quotient} HILO write.
import hilo_div_ctrl_pkg::*;

module hilo_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        annul_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        write_hilo_o,
    output logic        stall_o
);

    div_state_e  state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic        qneg, rneg;
    logic [31:0] step_rem;
    logic        step_q;
    logic        accept;

    assign accept = (start_i == DivStart) && !annul_i;

    hilo_div_ctrl_div_step u_div_step (
        .part_rem (rem),
        .dvd_bit  (dvd[31]),
        .divisor  (dvs),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DivFree;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DivFree:   if (accept) state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
            DivByZero: state_nxt = annul_i ? DivFree : DivEnd;
            DivOn: begin
                if (annul_i)           state_nxt = DivFree;
                else if (cnt == 6'd31) state_nxt = DivEnd;
            end
            DivEnd:    state_nxt = DivFree;
            default:   state_nxt = DivFree;
        endcase
    end

    // dvd shifts dividend bits out of the top while quotient bits fill in from the bottom
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dvd  <= '0;
            dvs  <= '0;
            rem  <= '0;
            qneg <= 1'b0;
            rneg <= 1'b0;
        end else begin
            unique case (state)
                DivFree: begin
                    if (accept) begin
                        cnt  <= '0;
                        rem  <= '0;
                        dvd  <= (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
                        dvs  <= (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
                        qneg <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                        rneg <= signed_i & opdata1_i[31];
                    end
                end
                DivByZero: begin
                    dvd  <= '0;
                    rem  <= '0;
                    qneg <= 1'b0;
                    rneg <= 1'b0;
                end
                DivOn: begin
                    rem <= step_rem;
                    dvd <= {dvd[30:0], step_q};
                    cnt <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ready_o  = DivResultNotReady;
        result_o = '0;
        stall_o  = DivStop;
        unique case (state)
            DivFree:          stall_o = accept ? DivStart : DivStop;
            DivByZero, DivOn: stall_o = DivStart;
            DivEnd: begin
                if (!annul_i) begin
                    ready_o  = DivResultReady;
                    result_o = {(rneg ? -rem : rem), (qneg ? -dvd : dvd)};
                end
            end
            default: ;
        endcase
    end

    assign write_hilo_o = ready_o;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: directed corner cases plus random
// divides compared against an arithmetic reference model.
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, signed_i, annul_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic [63:0] result_o;
    logic        ready_o, write_hilo_o, stall_o;

    int checks = 0;
    int errors = 0;

    hilo_div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_i     (signed_i),
        .annul_i      (annul_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .write_hilo_o (write_hilo_o),
        .stall_o      (stall_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'h0;
        if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Drives one divide from an IDLE cycle and reports what was observed.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res, output logic wr,
                           output logic stall0, output logic stall_gap, output logic stall_end);
        @(negedge clk);
        start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
        #1 stall0 = stall_o;
        lat = -1; res = '0; wr = 1'b0; stall_gap = 1'b0; stall_end = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            opdata1_i = $urandom; opdata2_i = $urandom; signed_i = $urandom_range(0, 1);
            #1;
            if (ready_o) begin
                lat = c; res = result_o; wr = write_hilo_o; stall_end = stall_o;
                break;
            end
            if (!stall_o) stall_gap = 1'b1;
        end
    endtask

    task automatic check_div(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int lat; logic [63:0] res; logic wr, s0, sg, se;
        int exp_lat;
        logic [63:0] exp_res;
        exp_lat = (b == 32'd0) ? 2 : 33;
        exp_res = model_div(sgn, a, b);
        run_div(sgn, a, b, lat, res, wr, s0, sg, se);
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL %s result got %h want %h", name, res, exp_res); end
        checks++;
        if (wr !== 1'b1) begin errors++; $display("FAIL %s write_hilo got %b want 1", name, wr); end
        checks++;
        if ({s0, sg, se} !== 3'b100) begin errors++; $display("FAIL %s stall start/gap/end got %b want 100", name, {s0, sg, se}); end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({result_o, ready_o, write_hilo_o, stall_o} !== 67'h0) begin
            errors++; $display("FAIL reset outputs got %h/%b/%b/%b want 0", result_o, ready_o, write_hilo_o, stall_o);
        end
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++; $display("FAIL idle outputs stall %b ready %b want 0 0", stall_o, ready_o);
        end
    endtask

    task automatic test_divu_basic;
        check_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    endtask

    task automatic test_signed;
        check_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        check_div("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    endtask

    task automatic test_divzero;
        check_div("div_5_0", 1'b1, 32'd5, 32'd0);
        check_div("divu_5_0", 1'b0, 32'hDEAD_BEEF, 32'd0);
    endtask

    task automatic test_overflow;
        check_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_div("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_annul;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'h10;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (c == 10) annul_i = 1'b1;
            #1 if (ready_o || write_hilo_o) seen = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL annul stall at cycle 11 got %b want 0", stall_o); end
        repeat (35) begin
            @(negedge clk);
            #1 if (ready_o || write_hilo_o) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL annul write seen got %b want 0", seen); end
        // annul together with start in IDLE must be ignored
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd8; opdata2_i = 32'd2;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL annul_start stall got %b want 0", stall_o); end
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL annul_start busy got %b want 0", stall_o); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({result_o, ready_o, write_hilo_o, stall_o} !== 67'h0) begin
            errors++; $display("FAIL reset_mid outputs got %h/%b/%b/%b want 0", result_o, ready_o, write_hilo_o, stall_o);
        end
        @(negedge clk); rst = 1'b0;
        check_div("divu_9_3", 1'b0, 32'd9, 32'd3);
    endtask

    task automatic test_back_to_back;
        check_div("b2b_first", 1'b1, 32'hFFFF_FC18, 32'd37);
        check_div("b2b_second", 1'b0, 32'h1234_5678, 32'h0000_0100);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic sgn;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(1, 15);
                1: b = 32'd0;
                2: b = $urandom | 32'h8000_0000;
                default: b = $urandom;
            endcase
            sgn = $urandom_range(0, 1);
            check_div($sformatf("rand%0d", i), sgn, a, b);
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        test_reset;
        test_divu_basic;
        test_signed;
        test_divzero;
        test_overflow;
        test_annul;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Iterative 32-bit divide controller that owns the HILO write path for DIV/DIVU. It sits in the execute stage beside the ALU and takes operands and a start request from the decoded instruction. It sequences a radix-2 restoring divide over 32 cycles and stalls the pipeline while busy. On completion it presents {remainder, quotient} for a single-cycle HILO write.

## Interface
- No parameters; data width is fixed at 32 bits.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- start_i  in  1  begin a divide; sampled only in IDLE
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i
- annul_i  in  1  abort the in-flight divide (branch flush or exception)
- opdata1_i  in  32  dividend; sampled with start_i
- opdata2_i  in  32  divisor; sampled with start_i
- result_o  out  64  {HI = remainder, LO = quotient}; valid only while ready_o = 1
- ready_o  out  1  result valid this cycle
- write_hilo_o  out  1  HILO write strobe; equals ready_o
- stall_o  out  1  hold upstream pipeline stages

## Operation
- States:
  - IDLE: waiting for start_i.
  - DIVZERO: divisor is zero.
  - ON: one quotient bit per cycle.
  - END: result presented.
- IDLE, start_i=1, annul_i=0:
  - Latch the operands and signed_i.
  - If signed, store the absolute values and record qneg = sign1^sign2 and rneg = sign1.
  - If divisor == 0, go to DIVZERO; otherwise clear the bit counter and go to ON.
- ON, each cycle:
  - Compute the trial difference = {partial_rem[31:0], next dividend bit} − divisor as a 33-bit subtract.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Increment the counter. After the 32nd step, go to END.
- DIVZERO: the result is forced to 64'h0, then go to END.
- END:
  - Apply signs: quotient is negated if qneg; remainder is negated if rneg.
  - Assert ready_o and write_hilo_o for exactly one cycle, then return to IDLE.
- annul_i in DIVZERO, ON or END:
  - Next state is IDLE.
  - No write occurs: ready_o is forced to 0 in the annulled cycle.
- annul_i together with start_i in IDLE: the start is ignored.
- start_i outside IDLE is ignored; the decoder guarantees the stall holds it.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient is 0x80000000 and remainder is 0. No trap.

## Timing
- Reset: state = IDLE; result_o = 0, ready_o = 0, write_hilo_o = 0, stall_o = 0, counter = 0.
- stall_o is combinational:
  - 1 when (IDLE and start_i and !annul_i), or in DIVZERO, or in ON.
  - 0 in END, so the pipeline advances in the same cycle as the HILO write.
- Latency, with start accepted at cycle 0:
  - Normal divide: ON covers cycles 1–32, END/ready_o at cycle 33.
  - Divide by zero: DIVZERO at cycle 1, END at cycle 2.
- Back-to-back: a new start_i may be accepted in the cycle after END (IDLE), giving a minimum of 34 cycles per divide.
- Reset mid-operation: returns to IDLE immediately (asynchronous), with no write.

## Structure
- Shared defines header gets:
  - State encodings: DivFree, DivByZero, DivOn, DivEnd.
  - Constants DivResultReady / DivResultNotReady and DivStart / DivStop.
- One natural sub-module, div_step: the combinational 33-bit trial subtract and shift for a single iteration.
- The sign fix-up stays in the top-level FSM.

## Test plan
- DIVU 100 / 7, start at cycle 0 -> ready_o at cycle 33, result_o = {32'd2, 32'd14}; stall_o high for cycles 0–32.
- DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 7 / −2 -> LO = 0xFFFFFFFD, HI = 0x00000001.
- DIV 5 / 0 -> ready_o at cycle 2 with result_o = 0; stall_o low from cycle 2.
- DIVU 0xFFFFFFFF / 0x10, with annul_i pulsed at cycle 10 -> IDLE at cycle 11; ready_o and write_hilo_o never assert; stall_o low at cycle 11.
- DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0. DIVU of the same operands -> LO = 0, HI = 0x80000000.
- rst asserted at cycle 15 of a divide -> all outputs 0 immediately. A fresh DIVU 9 / 3 then completes with {0, 3}.
